count4_monitor: RTL and testbench
=================================

Name: count4_monitor

Overview:
- Passive observer for the 4-bit up/down/loadable counter bus in this design.
- Samples the counter's count output every clock and decodes which operation produced each transition: increment, decrement, or load/jump.
- Tracks the current counting direction in a small FSM.
- Keeps saturating per-operation event counts and a run length, for on-chip self-check and debug readout.

Parameters:
- WIDTH, 4, width of the observed count bus (must be >= 2 so that +1 and -1 differ).
- STAT_W, 8, width of each statistics counter and of run_len.

Ports:
- clk  input  1  system clock; all state updates on the rising edge.
- reset  input  1  asynchronous, active-low reset.
- count_in  input  WIDTH  observed counter value.
- clr  input  1  synchronous clear of statistics and direction FSM.
- op_valid  output  1  op_code and jump_val are meaningful.
- op_code  output  2  decoded operation: 00 none, 01 INC, 10 DEC, 11 JUMP.
- jump_val  output  WIDTH  destination value of the most recent JUMP.
- dir  output  2  direction: 00 SYNC/IDLE, 01 UP, 10 DOWN.
- run_len  output  STAT_W  consecutive identical ops, including the current one.
- inc_cnt  output  STAT_W  total INC events.
- dec_cnt  output  STAT_W  total DEC events.
- jump_cnt  output  STAT_W  total JUMP events.

Behaviour:
- Reset (reset=0, asynchronous):
  - prev and have_prev clear.
  - op_valid=0, op_code=00, jump_val=0, dir=00, run_len=0, all counts=0.
  - FSM enters IDLE.
- Sampling: on every rising edge, prev <= count_in and have_prev <= 1. The first edge after reset release only primes prev.
- Classification at an edge, for cur=count_in, with have_prev=1; all arithmetic is modulo 2^WIDTH:
  - cur == prev+1 gives INC (15->0 is INC).
  - cur == prev-1 gives DEC (0->15 is DEC).
  - Anything else gives JUMP, including cur == prev (a hold is not a legal counter step).
- Outputs are registered and update on the same edge that samples cur. Latency is zero cycles after the edge that captures the second value.
  - op_valid=1 from the second post-reset edge onward.
  - op_code is the classification.
  - jump_val <= cur on JUMP only; otherwise it holds.
- FSM, advancing only when have_prev=1:
  - IDLE -> SYNC on the first sample.
  - SYNC: INC -> UP; DEC -> DOWN; JUMP -> SYNC.
  - UP: INC stays in UP; DEC -> DOWN; JUMP -> SYNC.
  - DOWN: DEC stays in DOWN; INC -> UP; JUMP -> SYNC.
  - dir encodes the state: IDLE and SYNC both give 00.
- run_len:
  - Set to 1 when op_code differs from the previous valid op_code, or on the first valid op.
  - Otherwise increments, saturating at 2^STAT_W-1.
- Statistics:
  - The counter matching the decoded op increments by 1, saturating at 2^STAT_W-1 with no wrap.
  - Counters never decrement.
- clr=1 at an edge:
  - inc_cnt, dec_cnt, jump_cnt and run_len <= 0; FSM <= SYNC if have_prev, else IDLE.
  - clr has priority over any event at the same edge; that event is not counted and does not move the FSM.
  - op_valid, op_code, jump_val and prev still update normally.
- Reset asserted mid-stream: everything returns to reset values immediately. The first edge after release is again a priming edge with no op_valid.
- No X propagation: all outputs have defined values from reset onward.

Test Plan:
- Release reset, drive count_in 3,4,5,6 on successive edges -> op_valid=0 after the edge sampling 3; INC on the next three edges; dir=01; run_len=3; inc_cnt=3.
- Drive 14,15,0,1 then 0,15 -> 15->0 and 0->1 decode as INC; 1->0 and 0->15 decode as DEC; dir goes 01 then 10; run_len restarts at 1 on 1->0 and reaches 2 after 0->15; dec_cnt=2.
- From 5 drive 9, then hold 9 -> two JUMPs; jump_val=9; dir=00; jump_cnt=2; run_len=2.
- With STAT_W=8, drive 256 consecutive INCs -> inc_cnt=255 and run_len=255; both hold at 255 with no wrap.
- Assert clr on the edge of an INC (7->8) after inc_cnt=5 -> inc_cnt=0, dir=00, op_code=01 still reported. The next INC gives inc_cnt=1 and dir=01.
- Pull reset low mid-run (dir=10, dec_cnt=4) -> all outputs are 0 immediately. After release, the first edge gives op_valid=0, and the second reports the freshly decoded op.

Source files
------------

// File: rtl/count4_monitor_if.sv
// Bundle between the observed counter bus and the count4_monitor observer.
// The slave modport is the monitor's view. The master modport is the
// driver/reader on the other side, for example a debug block or a testbench.
interface count4_monitor_if #(
    parameter int WIDTH  = 4,
    parameter int STAT_W = 8
);
    // count_in and clr are sampled on every rising clock edge. No handshake
    // applies to them. op_valid qualifies op_code and jump_val: when it is 0,
    // those two fields carry no information.
    logic [WIDTH-1:0]  count_in;
    logic              clr;
    logic              op_valid;
    logic [1:0]        op_code;
    logic [WIDTH-1:0]  jump_val;
    logic [1:0]        dir;
    logic [STAT_W-1:0] run_len;
    logic [STAT_W-1:0] inc_cnt;
    logic [STAT_W-1:0] dec_cnt;
    logic [STAT_W-1:0] jump_cnt;
    logic [1:0]        dbg_state;

    modport slave (
        input  count_in,
        input  clr,
        output op_valid,
        output op_code,
        output jump_val,
        output dir,
        output run_len,
        output inc_cnt,
        output dec_cnt,
        output jump_cnt,
        output dbg_state
    );

    modport master (
        output count_in,
        output clr,
        input  op_valid,
        input  op_code,
        input  jump_val,
        input  dir,
        input  run_len,
        input  inc_cnt,
        input  dec_cnt,
        input  jump_cnt,
        input  dbg_state
    );
endinterface

// File: rtl/count4_monitor.sv
// Passive observer for a small up/down/loadable counter. Each edge compares
// the sampled count against the previous sample and decodes INC, DEC or JUMP.
// It tracks the counting direction and keeps saturating event statistics.
module count4_monitor #(
    parameter int WIDTH  = 4,
    parameter int STAT_W = 8
) (
    input  logic              clk,
    input  logic              reset,
    count4_monitor_if.slave   bus
);

    localparam logic [1:0] OP_NONE = 2'b00;
    localparam logic [1:0] OP_INC  = 2'b01;
    localparam logic [1:0] OP_DEC  = 2'b10;
    localparam logic [1:0] OP_JUMP = 2'b11;

    // IDLE means no sample has been taken yet. SYNC means the direction is
    // unknown, either after a jump or after a clear.
    typedef enum logic [1:0] {
        ST_IDLE = 2'b00,
        ST_SYNC = 2'b01,
        ST_UP   = 2'b10,
        ST_DOWN = 2'b11
    } state_t;

    logic [WIDTH-1:0]  prev_q;
    logic              have_prev_q;
    logic              op_valid_q;
    logic [1:0]        op_code_q;
    logic [WIDTH-1:0]  jump_val_q;
    state_t            state_q;
    state_t            state_nxt;
    logic [1:0]        dir_q;
    logic [1:0]        dir_nxt;
    logic [STAT_W-1:0] run_len_q;
    logic [STAT_W-1:0] inc_cnt_q;
    logic [STAT_W-1:0] dec_cnt_q;
    logic [STAT_W-1:0] jump_cnt_q;

    logic [WIDTH-1:0]  prev_plus;
    logic [WIDTH-1:0]  prev_minus;
    logic [1:0]        op_cls;

    // Saturating +1. An all-ones value stays put instead of wrapping to zero.
    function automatic logic [STAT_W-1:0] sat_inc(input logic [STAT_W-1:0] v);
        logic [STAT_W-1:0] r;
        r = v;
        if (v != {STAT_W{1'b1}}) begin
            r = v + {{(STAT_W-1){1'b0}}, 1'b1};
        end
        return r;
    endfunction

    // Decode the transition prev -> count_in. Arithmetic wraps at WIDTH bits,
    // and a held value counts as a jump.
    always_comb begin
        prev_plus  = prev_q + {{(WIDTH-1){1'b0}}, 1'b1};
        prev_minus = prev_q - {{(WIDTH-1){1'b0}}, 1'b1};
        op_cls     = OP_JUMP;
        if (bus.count_in == prev_plus) begin
            op_cls = OP_INC;
        end else if (bus.count_in == prev_minus) begin
            op_cls = OP_DEC;
        end
    end

    // Next direction state. A clear overrides the decoded event.
    always_comb begin
        state_nxt = state_q;
        if (have_prev_q) begin
            unique case (state_q)
                ST_IDLE: state_nxt = ST_SYNC;
                ST_SYNC: begin
                    if (op_cls == OP_INC)      state_nxt = ST_UP;
                    else if (op_cls == OP_DEC) state_nxt = ST_DOWN;
                    else                       state_nxt = ST_SYNC;
                end
                ST_UP: begin
                    if (op_cls == OP_INC)      state_nxt = ST_UP;
                    else if (op_cls == OP_DEC) state_nxt = ST_DOWN;
                    else                       state_nxt = ST_SYNC;
                end
                ST_DOWN: begin
                    if (op_cls == OP_DEC)      state_nxt = ST_DOWN;
                    else if (op_cls == OP_INC) state_nxt = ST_UP;
                    else                       state_nxt = ST_SYNC;
                end
                default: state_nxt = ST_IDLE;
            endcase
        end
        if (bus.clr) begin
            state_nxt = have_prev_q ? ST_SYNC : ST_IDLE;
        end
        dir_nxt = 2'b00;
        if (state_nxt == ST_UP)   dir_nxt = 2'b01;
        if (state_nxt == ST_DOWN) dir_nxt = 2'b10;
    end

    // Direction FSM with a registered dir output.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= ST_IDLE;
            dir_q   <= 2'b00;
        end else begin
            state_q <= state_nxt;
            dir_q   <= dir_nxt;
        end
    end

    // Sample history and decoded-op outputs. clr does not affect these.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            prev_q      <= '0;
            have_prev_q <= 1'b0;
            op_valid_q  <= 1'b0;
            op_code_q   <= OP_NONE;
            jump_val_q  <= '0;
        end else begin
            prev_q      <= bus.count_in;
            have_prev_q <= 1'b1;
            if (have_prev_q) begin
                op_valid_q <= 1'b1;
                op_code_q  <= op_cls;
                if (op_cls == OP_JUMP) begin
                    jump_val_q <= bus.count_in;
                end
            end
        end
    end

    // Saturating statistics and run length. clr wins over an event at the same edge.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            run_len_q  <= '0;
            inc_cnt_q  <= '0;
            dec_cnt_q  <= '0;
            jump_cnt_q <= '0;
        end else if (bus.clr) begin
            run_len_q  <= '0;
            inc_cnt_q  <= '0;
            dec_cnt_q  <= '0;
            jump_cnt_q <= '0;
        end else if (have_prev_q) begin
            if (!op_valid_q || (op_code_q != op_cls)) begin
                run_len_q <= {{(STAT_W-1){1'b0}}, 1'b1};
            end else begin
                run_len_q <= sat_inc(run_len_q);
            end
            unique case (op_cls)
                OP_INC:  inc_cnt_q  <= sat_inc(inc_cnt_q);
                OP_DEC:  dec_cnt_q  <= sat_inc(dec_cnt_q);
                default: jump_cnt_q <= sat_inc(jump_cnt_q);
            endcase
        end
    end

    assign bus.op_valid  = op_valid_q;
    assign bus.op_code   = op_code_q;
    assign bus.jump_val  = jump_val_q;
    assign bus.dir       = dir_q;
    assign bus.run_len   = run_len_q;
    assign bus.inc_cnt   = inc_cnt_q;
    assign bus.dec_cnt   = dec_cnt_q;
    assign bus.jump_cnt  = jump_cnt_q;
    assign bus.dbg_state = state_q;

endmodule

// File: tb/tb_count4_monitor.sv
// Directed bench for count4_monitor. It steps count_in one edge at a time and
// checks the registered outputs 1 ns after each rising edge against
// hand-computed values.
module tb_count4_monitor;

    logic clk;
    logic reset;
    int   checks;
    int   errors;
    logic [3:0] v;

    count4_monitor_if #(.WIDTH(4), .STAT_W(8)) bus ();

    count4_monitor #(.WIDTH(4), .STAT_W(8)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus.slave)
    );

    // Clock generation.
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    // Drive one value, then wait for it to be sampled and let outputs settle.
    task automatic step(input logic [3:0] val);
        bus.count_in = val;
        @(posedge clk);
        #1;
    endtask

    initial begin
        checks       = 0;
        errors       = 0;
        reset        = 1'b0;
        bus.count_in = 4'd0;
        bus.clr      = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check("rst_op_valid", 32'(bus.op_valid), 32'd0);
        check("rst_op_code",  32'(bus.op_code),  32'd0);
        check("rst_jump_val", 32'(bus.jump_val), 32'd0);
        check("rst_dir",      32'(bus.dir),      32'd0);
        check("rst_run_len",  32'(bus.run_len),  32'd0);
        check("rst_counts",   32'({bus.inc_cnt, bus.dec_cnt, bus.jump_cnt}), 32'd0);
        reset = 1'b1;

        // 3,4,5,6: priming edge, then three INCs.
        step(4'd3);
        check("prime_op_valid", 32'(bus.op_valid), 32'd0);
        check("prime_op_code",  32'(bus.op_code),  32'd0);
        step(4'd4);
        check("inc1_op_valid", 32'(bus.op_valid), 32'd1);
        check("inc1_op_code",  32'(bus.op_code),  32'd1);
        check("inc1_run_len",  32'(bus.run_len),  32'd1);
        step(4'd5);
        step(4'd6);
        check("inc3_op_code", 32'(bus.op_code), 32'd1);
        check("inc3_dir",     32'(bus.dir),     32'd1);
        check("inc3_run_len", 32'(bus.run_len), 32'd3);
        check("inc3_inc_cnt", 32'(bus.inc_cnt), 32'd3);

        // 6->14 jump, then 15,0,1 (wrap INC), then 0,15 (wrap DEC).
        step(4'd14);
        check("j14_op_code",  32'(bus.op_code),  32'd3);
        check("j14_jump_val", 32'(bus.jump_val), 32'd14);
        check("j14_dir",      32'(bus.dir),      32'd0);
        check("j14_run_len",  32'(bus.run_len),  32'd1);
        step(4'd15);
        check("i15_dir", 32'(bus.dir), 32'd1);
        step(4'd0);
        check("wrap_inc_op", 32'(bus.op_code), 32'd1);
        step(4'd1);
        check("i1_run_len", 32'(bus.run_len), 32'd3);
        check("i1_inc_cnt", 32'(bus.inc_cnt), 32'd6);
        step(4'd0);
        check("d0_op_code", 32'(bus.op_code), 32'd2);
        check("d0_dir",     32'(bus.dir),     32'd2);
        check("d0_run_len", 32'(bus.run_len), 32'd1);
        step(4'd15);
        check("wrap_dec_op",  32'(bus.op_code),  32'd2);
        check("d15_run_len",  32'(bus.run_len),  32'd2);
        check("d15_dec_cnt",  32'(bus.dec_cnt),  32'd2);
        check("d15_jump_val", 32'(bus.jump_val), 32'd14);

        // 15->5, 5->9 and a hold at 9: all three are jumps.
        step(4'd5);
        step(4'd9);
        check("j9_jump_val", 32'(bus.jump_val), 32'd9);
        step(4'd9);
        check("hold_op_code",  32'(bus.op_code),  32'd3);
        check("hold_jump_val", 32'(bus.jump_val), 32'd9);
        check("hold_dir",      32'(bus.dir),      32'd0);
        check("hold_jump_cnt", 32'(bus.jump_cnt), 32'd4);
        check("hold_run_len",  32'(bus.run_len),  32'd3);

        // 9->7 jump, then clr on a 7->8 INC edge.
        step(4'd7);
        check("j7_inc_cnt", 32'(bus.inc_cnt), 32'd6);
        bus.clr = 1'b1;
        step(4'd8);
        bus.clr = 1'b0;
        check("clr_inc_cnt",  32'(bus.inc_cnt),  32'd0);
        check("clr_dec_cnt",  32'(bus.dec_cnt),  32'd0);
        check("clr_jump_cnt", 32'(bus.jump_cnt), 32'd0);
        check("clr_run_len",  32'(bus.run_len),  32'd0);
        check("clr_dir",      32'(bus.dir),      32'd0);
        check("clr_op_code",  32'(bus.op_code),  32'd1);
        check("clr_op_valid", 32'(bus.op_valid), 32'd1);
        step(4'd9);
        check("postclr_inc_cnt", 32'(bus.inc_cnt), 32'd1);
        check("postclr_dir",     32'(bus.dir),     32'd1);
        check("postclr_run_len", 32'(bus.run_len), 32'd1);

        // Long INC run: counters reach 255 and stay there.
        v = 4'd9;
        for (int i = 0; i < 253; i++) begin
            v = v + 4'd1;
            step(v);
        end
        check("sat254_inc_cnt", 32'(bus.inc_cnt), 32'd254);
        check("sat254_run_len", 32'(bus.run_len), 32'd254);
        v = v + 4'd1;
        step(v);
        check("sat255_inc_cnt", 32'(bus.inc_cnt), 32'd255);
        check("sat255_run_len", 32'(bus.run_len), 32'd255);
        for (int i = 0; i < 5; i++) begin
            v = v + 4'd1;
            step(v);
        end
        check("sathold_inc_cnt", 32'(bus.inc_cnt), 32'd255);
        check("sathold_run_len", 32'(bus.run_len), 32'd255);

        // Four DECs, then an asynchronous reset in the middle of a cycle.
        for (int i = 0; i < 4; i++) begin
            v = v - 4'd1;
            step(v);
        end
        check("dn_dir",     32'(bus.dir),     32'd2);
        check("dn_dec_cnt", 32'(bus.dec_cnt), 32'd4);
        check("dn_run_len", 32'(bus.run_len), 32'd4);
        #2;
        reset = 1'b0;
        #1;
        check("arst_op_valid", 32'(bus.op_valid), 32'd0);
        check("arst_op_code",  32'(bus.op_code),  32'd0);
        check("arst_jump_val", 32'(bus.jump_val), 32'd0);
        check("arst_dir",      32'(bus.dir),      32'd0);
        check("arst_run_len",  32'(bus.run_len),  32'd0);
        check("arst_counts",   32'({bus.inc_cnt, bus.dec_cnt, bus.jump_cnt}), 32'd0);
        @(posedge clk);
        #1;
        reset = 1'b1;
        step(4'd2);
        check("reprime_op_valid", 32'(bus.op_valid), 32'd0);
        step(4'd3);
        check("reinc_op_valid", 32'(bus.op_valid), 32'd1);
        check("reinc_op_code",  32'(bus.op_code),  32'd1);
        check("reinc_inc_cnt",  32'(bus.inc_cnt),  32'd1);
        check("reinc_run_len",  32'(bus.run_len),  32'd1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
